// File: rtl/lan_bus_arbiter.sv
// lan_bus_arbiter
//   Two-requester round-robin arbiter in front of an asynchronous LAN-chip bus.
//   Each granted transaction runs SETUP -> STROBE -> HOLD with per-phase cycle
//   counts, then pulses Ack to the owner. A requester holding Lock at its Ack
//   keeps ownership for its next request.
// Ports
//   Clk, RstN            clock, asynchronous active-low reset
//   Req/Wr/Lock [1:0]    per-requester request, write select, lock
//   Addr0/Addr1 [9:0]    per-requester word address
//   WData0/WData1 [15:0] per-requester write data
//   Grant [1:0]          one-hot owner (combinational winner while IDLE)
//   Ack [1:0]            one-cycle completion pulse
//   RData [15:0]         last read data, held until the next read completes
//   Busy                 high outside IDLE
//   LanAddr, LanData     chip address bus, bidirectional chip data bus
//   LanCs/LanRd/LanWr    active-low chip strobes
module lan_bus_arbiter #(
  parameter int unsigned SETUP_CYC  = 5,
  parameter int unsigned STROBE_CYC = 5,
  parameter int unsigned HOLD_CYC   = 5
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic [1:0]  Req,
  input  logic [1:0]  Wr,
  input  logic [1:0]  Lock,
  input  logic [9:0]  Addr0,
  input  logic [9:0]  Addr1,
  input  logic [15:0] WData0,
  input  logic [15:0] WData1,
  output logic [1:0]  Grant,
  output logic [1:0]  Ack,
  output logic [15:0] RData,
  output logic        Busy,
  output logic [9:0]  LanAddr,
  inout  logic [15:0] LanData,
  output logic        LanCs,
  output logic        LanRd,
  output logic        LanWr
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        owner;     // current / most recent owner; doubles as round-robin pointer
  logic        lock_q;
  logic        wr_q;
  logic [9:0]  addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rdata_q;
  logic        grant_now;
  logic        win;
  logic        last_cyc;

  // Arbitration: a live lock overrides round-robin; on a tie the requester
  // that did not own the bus last wins.
  always_comb begin
    grant_now = |Req;
    win       = 1'b0;
    if (lock_q && Req[owner])
      win = owner;
    else if (Req == 2'b11)
      win = ~owner;
    else
      win = Req[1];
  end

  assign last_cyc = (cnt == '0);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (grant_now) begin
          state_nx = SETUP;
          cnt_nx   = 4'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (last_cyc) begin
          state_nx = STROBE;
          cnt_nx   = 4'(STROBE_CYC - 1);
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (last_cyc) begin
          state_nx = HOLD;
          cnt_nx   = 4'(HOLD_CYC - 1);
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (last_cyc) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Transaction latch, lock and read capture. owner resets to 1 so that
  // requester 0 wins the first tie. Any new grant clears the lock; it is
  // re-armed from the owner's Lock bit at each Ack.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      owner   <= 1'b1;
      lock_q  <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE) begin
        if (grant_now) begin
          owner   <= win;
          wr_q    <= Wr[win];
          addr_q  <= win ? Addr1 : Addr0;
          wdata_q <= win ? WData1 : WData0;
        end
        if (grant_now || !Req[owner])
          lock_q <= 1'b0;
      end
      if (state == STROBE && last_cyc && !wr_q)
        rdata_q <= LanData;
      if (state == HOLD && last_cyc)
        lock_q <= Lock[owner];
    end
  end

  always_comb begin
    Grant = '0;
    if (RstN) begin
      if (state == IDLE)
        Grant = grant_now ? (win ? 2'b10 : 2'b01) : 2'b00;
      else
        Grant = owner ? 2'b10 : 2'b01;
    end
  end

  assign Ack     = (state == HOLD && last_cyc) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign RData   = rdata_q;
  assign Busy    = (state != IDLE);
  assign LanAddr = addr_q;
  assign LanCs   = ~(state == STROBE);
  assign LanWr   = ~(state == STROBE && wr_q);
  assign LanRd   = ~(state == STROBE && !wr_q);
  assign LanData = (state != IDLE && wr_q) ? wdata_q : 'z;

endmodule

// File: tb/tb_lan_bus_arbiter.sv
// tb_lan_bus_arbiter
//   Directed bench for lan_bus_arbiter with default timing (5/5/5).
//   A simple chip model drives LanData while LanRd is low; a bus monitor
//   checks strobe rules, one-hot Grant and single-cycle Ack every cycle.
module tb_lan_bus_arbiter;

  logic        Clk;
  logic        RstN;
  logic [1:0]  Req;
  logic [1:0]  Wr;
  logic [1:0]  Lock;
  logic [9:0]  Addr0, Addr1;
  logic [15:0] WData0, WData1;
  logic [1:0]  Grant;
  logic [1:0]  Ack;
  logic [15:0] RData;
  logic        Busy;
  logic [9:0]  LanAddr;
  wire  [15:0] lan_data;
  logic        LanCs, LanRd, LanWr;

  logic [15:0] mdl_val;

  int n_vec;
  int n_err;

  lan_bus_arbiter #(.SETUP_CYC(5), .STROBE_CYC(5), .HOLD_CYC(5)) dut (
    .Clk(Clk), .RstN(RstN), .Req(Req), .Wr(Wr), .Lock(Lock),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Grant(Grant), .Ack(Ack), .RData(RData), .Busy(Busy),
    .LanAddr(LanAddr), .LanData(lan_data),
    .LanCs(LanCs), .LanRd(LanRd), .LanWr(LanWr)
  );

  assign lan_data = (!LanRd) ? mdl_val : 'z;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Bus monitor
  logic [1:0] ack_prev;
  initial ack_prev = 2'b00;
  always @(negedge Clk) begin
    #2;
    chk("mon_rd_wr_both", {31'd0, (!LanRd && !LanWr)}, 32'd0);
    chk("mon_strobe_no_cs", {31'd0, ((!LanRd || !LanWr) && LanCs)}, 32'd0);
    chk("mon_grant_onehot", {31'd0, $onehot0(Grant)}, 32'd1);
    chk("mon_ack_width", {30'd0, (Ack & ack_prev)}, 32'd0);
    ack_prev = Ack;
  end

  // Results of one single-requester transaction
  int          first_cs, n_cs, n_wr, n_rd, ack_cyc;
  logic [1:0]  ack_val, grant1;
  logic [9:0]  bus_addr;
  logic [15:0] bus_data, rd_at_ack;

  task automatic do_txn(input int r, input logic wr, input logic [9:0] a,
                        input logic [15:0] d, input logic scramble, input logic drop_req);
    first_cs = 0; n_cs = 0; n_wr = 0; n_rd = 0; ack_cyc = 0;
    ack_val = '0; grant1 = '0; bus_addr = '0; bus_data = '0; rd_at_ack = '0;
    @(negedge Clk);
    Wr[r] = wr;
    if (r == 0) begin Addr0 = a; WData0 = d; end
    else        begin Addr1 = a; WData1 = d; end
    Req[r] = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) @(negedge Clk);
      #1;
      if (c == 1) grant1 = Grant;
      if (c == 3 && scramble) begin
        Wr[r] = ~wr;
        if (r == 0) begin Addr0 = ~a; WData0 = ~d; end
        else        begin Addr1 = ~a; WData1 = ~d; end
      end
      if (c == 5 && drop_req) Req[r] = 1'b0;
      if (!LanCs) begin
        if (first_cs == 0) first_cs = c;
        n_cs++;
        bus_addr = LanAddr;
        bus_data = lan_data;
      end
      if (!LanWr) n_wr++;
      if (!LanRd) n_rd++;
      if (Ack != 2'b00 && ack_cyc == 0) begin
        ack_cyc   = c;
        ack_val   = Ack;
        rd_at_ack = RData;
        Req[r]    = 1'b0;
      end
    end
    Wr[r] = wr;
  endtask

  // Waits for the next Ack, n = negedges waited; n = -1 on timeout.
  task automatic wait_ack(output logic [1:0] a, output int n);
    a = '0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      #1;
      if (Ack != 2'b00) begin
        a = Ack;
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    RstN = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #1 RstN = 1'b1;
  endtask

  logic [1:0] a;
  int         n;
  int         acks_in_rst;

  initial begin
    n_vec = 0; n_err = 0;
    RstN = 1'b0; Req = '0; Wr = '0; Lock = '0;
    Addr0 = '0; Addr1 = '0; WData0 = '0; WData1 = '0;
    mdl_val = 16'h0017;

    // Reset values
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_grant", {30'd0, Grant}, 32'd0);
    chk("rst_ack", {30'd0, Ack}, 32'd0);
    chk("rst_rdata", {16'd0, RData}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_addr", {22'd0, LanAddr}, 32'd0);
    chk("rst_strobes", {29'd0, LanCs, LanRd, LanWr}, 32'h7);
    RstN = 1'b1;

    // Write from requester 0, inputs changed mid-transaction
    do_txn(0, 1'b1, 10'h20A, 16'h0050, 1'b1, 1'b0);
    chk("wr_grant", {30'd0, grant1}, 32'h1);
    chk("wr_cs_first", first_cs, 7);
    chk("wr_cs_len", n_cs, 5);
    chk("wr_wr_len", n_wr, 5);
    chk("wr_rd_len", n_rd, 0);
    chk("wr_addr", {22'd0, bus_addr}, 32'h20A);
    chk("wr_data", {16'd0, bus_data}, 32'h0050);
    chk("wr_ack_cyc", ack_cyc, 16);
    chk("wr_ack_val", {30'd0, ack_val}, 32'h1);

    // Read from requester 1, Req dropped before Ack
    do_txn(1, 1'b0, 10'h208, 16'h0000, 1'b0, 1'b1);
    chk("rd_grant", {30'd0, grant1}, 32'h2);
    chk("rd_cs_first", first_cs, 7);
    chk("rd_rd_len", n_rd, 5);
    chk("rd_wr_len", n_wr, 0);
    chk("rd_addr", {22'd0, bus_addr}, 32'h208);
    chk("rd_rdata", {16'd0, rd_at_ack}, 32'h0017);
    chk("rd_ack_cyc", ack_cyc, 16);
    chk("rd_ack_val", {30'd0, ack_val}, 32'h2);

    // RData holds across a later write
    do_txn(0, 1'b1, 10'h001, 16'hBEEF, 1'b0, 1'b0);
    chk("rdata_hold", {16'd0, RData}, 32'h0017);
    chk("wr2_data", {16'd0, bus_data}, 32'hBEEF);

    // Round-robin with both requesting continuously
    pulse_reset();
    Wr = 2'b11;
    Req = 2'b11;
    wait_ack(a, n);
    chk("rr_ack0", {30'd0, a}, 32'h1);
    chk("rr_lat0", n, 15);
    wait_ack(a, n);
    chk("rr_ack1", {30'd0, a}, 32'h2);
    chk("rr_gap1", n, 16);
    wait_ack(a, n);
    chk("rr_ack2", {30'd0, a}, 32'h1);
    wait_ack(a, n);
    chk("rr_ack3", {30'd0, a}, 32'h2);
    Req = 2'b00;

    // Lock on requester 0 for three transactions
    pulse_reset();
    Lock = 2'b01;
    Req  = 2'b11;
    wait_ack(a, n);
    chk("lk_ack0", {30'd0, a}, 32'h1);
    wait_ack(a, n);
    chk("lk_ack1", {30'd0, a}, 32'h1);
    @(negedge Clk);
    #1 Lock = 2'b00;
    wait_ack(a, n);
    chk("lk_ack2", {30'd0, a}, 32'h1);
    wait_ack(a, n);
    chk("lk_ack3", {30'd0, a}, 32'h2);
    Req = 2'b00;

    // Reset during STROBE
    @(negedge Clk);
    Wr[0] = 1'b1; Addr0 = 10'h155; WData0 = 16'h1234; Req[0] = 1'b1;
    repeat (7) @(negedge Clk);
    #1;
    chk("mr_in_strobe", {31'd0, LanCs}, 32'd0);
    RstN = 1'b0;
    #1;
    chk("mr_strobes", {29'd0, LanCs, LanRd, LanWr}, 32'h7);
    chk("mr_busy", {31'd0, Busy}, 32'd0);
    chk("mr_grant", {30'd0, Grant}, 32'd0);
    chk("mr_addr", {22'd0, LanAddr}, 32'd0);
    acks_in_rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      #1;
      if (Ack != 2'b00) acks_in_rst++;
    end
    chk("mr_no_ack", acks_in_rst, 0);
    RstN = 1'b1;
    wait_ack(a, n);
    chk("mr_reissue_ack", {30'd0, a}, 32'h1);
    chk("mr_reissue_lat", n, 15);
    Req = 2'b00;

    repeat (3) @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
